logic_op_pipe: RTL
==================

// Module: logic_op_pipe
// PURPOSE
//   Parametrised, registered bitwise logic unit: successor to the single-bit
//   combinational AND block. Applies one of eight 2-operand logic ops to
//   WIDTH-bit operands. Holds results in a 2-entry output buffer with a
//   valid/ready handshake on both sides. Sits between a stimulus/decode
//   front end and any consumer that may stall.
// PARAMETERS
//   WIDTH   8   operand/result width in bits (>=1)
//   CNT_W   16  width of accepted-transaction counter (>=1)
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous reset, active-low
//   in_valid   in   1        operand set valid
//   in_ready   out  1        unit can accept this cycle
//   in_a       in   WIDTH    operand A
//   in_b       in   WIDTH    operand B
//   in_op      in   3        0 AND,1 OR,2 XOR,3 NAND,4 NOR,5 XNOR,6 PASS_A,7 NOT_A
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer accepts result
//   out_y      out  WIDTH    result
//   out_zero   out  1        out_y == 0
//   out_ones   out  1        out_y all ones (reduction AND)
//   acc_cnt    out  CNT_W    count of accepted inputs, wraps modulo 2^CNT_W
// BEHAVIOUR
//   - Reset (async assert, sync release): buffer empty, out_valid=0,
//     out_y=0, out_zero=1, out_ones=0, acc_cnt=0, in_ready=1 after release.
//   - Accept when in_valid & in_ready. Drain when out_valid & out_ready.
//   - Result is computed combinationally from in_a/in_b/in_op at accept and
//     written into the 2-entry FIFO. Flags are stored with each entry.
//   - Latency: accept in cycle N -> out_valid=1 with result in cycle N+1
//     (buffer was empty). There is no combinational in->out path.
//   - in_ready = (entries < 2); it is a registered function of occupancy and
//     does not depend on out_ready in the same cycle.
//   - Occupancy: 0 -> 1 on accept. 1 -> 2 on accept without drain.
//     1 -> 0 on drain without accept. 1 -> 1 on accept+drain.
//     2 -> 1 on drain. At 2, no accept is possible.
//   - Output order is strict FIFO. out_y and flags are held stable while
//     out_valid & !out_ready.
//   - When out_valid=0: out_y=0, out_zero=1, out_ones=0.
//   - For the WIDTH=1 case, in_op=0 equals the legacy AND block's c output.
//   - acc_cnt increments by 1 on each accept. It wraps from all-ones to 0.
//   - An in_op change while in_valid is held low has no effect.
//   - Reset asserted mid-operation: buffer flushed immediately. Pending
//     results are lost and outputs return to reset values.
// CONFIGURATION
//   LOGIC_OP_PARITY_EN
//   - Defined: adds output port out_par (1 bit) = ^out_y, stored per entry.
//     out_par is 0 at reset and whenever out_valid=0.
//   - Undefined: port out_par is absent. No parity logic is generated.
//     All other behaviour is identical.
// TESTING
//   1 reset: rst_n=0 mid-run with 2 entries held -> next edge shows
//     out_valid=0, acc_cnt=0, out_zero=1; in_ready=1 after release.
//   2 op sweep, WIDTH=8: a=8'hC3, b=8'h5A, op 0..7 with out_ready=1 ->
//     y = 42,DB,99,BD,24,66,C3,3C, each one cycle after accept.
//   3 backpressure: out_ready=0, push 3 ops -> third stalls (in_ready=0
//     after 2 accepts); release out_ready -> two results in order, then third.
//   4 flags: a=8'hFF, b=8'hFF, op0 -> out_ones=1, out_zero=0;
//     op2 -> y=00, out_zero=1.
//   5 counter wrap, CNT_W=4: 17 accepts -> acc_cnt=1.
//   6 with LOGIC_OP_PARITY_EN: a=8'h07, b=8'h00, op1 -> y=07, out_par=1.

Source files
------------

// File: rtl/logic_op_pipe.sv
// Registered 8-op bitwise logic unit with a 2-entry valid/ready output FIFO.
// Define LOGIC_OP_PARITY_EN to add the out_par port (parity of out_y).
module logic_op_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_ones,
  output logic [CNT_W-1:0] acc_cnt
`ifdef LOGIC_OP_PARITY_EN
  ,
  output logic             out_par
`endif
);

  logic [WIDTH-1:0] y_q    [2];
  logic             zero_q [2];
  logic             ones_q [2];
`ifdef LOGIC_OP_PARITY_EN
  logic             par_q  [2];
`endif

  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] res;
  logic             acc;
  logic             drn;

  always_comb begin
    res = '0;
    case (in_op)
      3'd0: res = in_a & in_b;
      3'd1: res = in_a | in_b;
      3'd2: res = in_a ^ in_b;
      3'd3: res = ~(in_a & in_b);
      3'd4: res = ~(in_a | in_b);
      3'd5: res = ~(in_a ^ in_b);
      3'd6: res = in_a;
      3'd7: res = ~in_a;
      default: res = '0;
    endcase
  end

  // Ready depends only on stored occupancy, never on out_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;
  assign acc_cnt   = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      cnt_q     <= '0;
      y_q[0]    <= '0;
      y_q[1]    <= '0;
      zero_q[0] <= 1'b1;
      zero_q[1] <= 1'b1;
      ones_q[0] <= 1'b0;
      ones_q[1] <= 1'b0;
`ifdef LOGIC_OP_PARITY_EN
      par_q[0]  <= 1'b0;
      par_q[1]  <= 1'b0;
`endif
    end else begin
      if (acc) begin
        y_q[wr_ptr]    <= res;
        zero_q[wr_ptr] <= (res == '0);
        ones_q[wr_ptr] <= &res;
`ifdef LOGIC_OP_PARITY_EN
        par_q[wr_ptr]  <= ^res;
`endif
        wr_ptr         <= ~wr_ptr;
        cnt_q          <= cnt_q + CNT_W'(1);
      end
      if (drn)
        rd_ptr <= ~rd_ptr;
      case ({acc, drn})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Idle outputs are forced to the "empty" pattern.
  assign out_y    = out_valid ? y_q[rd_ptr] : '0;
  assign out_zero = out_valid ? zero_q[rd_ptr] : 1'b1;
  assign out_ones = out_valid & ones_q[rd_ptr];
`ifdef LOGIC_OP_PARITY_EN
  assign out_par  = out_valid & par_q[rd_ptr];
`endif

endmodule
